// File: rtl/ofmap_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ofmap_serializer_pkg
//   Shared conv-datapath definitions used by the ofmap serializer.
//   - ofmap_ser_state_t : serializer FSM states (IDLE, RUN, DONE)
//   - DEF_OFMAP_WIDTH   : default width of one ofmap result word
//   - DEF_ARRAY_WIDTH   : default words per drained line (OC0)
// ---------------------------------------------------------------------------
package ofmap_serializer_pkg;

  localparam int DEF_OFMAP_WIDTH = 32;
  localparam int DEF_ARRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ofmap_ser_state_t;

endpackage

// File: rtl/ofmap_serializer_line_fifo.sv
// ---------------------------------------------------------------------------
// line_fifo
//   Generic synchronous FIFO with first-word-fall-through head data.
//   DEPTH must be a power of two and at least 2.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (empties the FIFO)
//     push/push_dat write push_dat when push && !full
//     pop           drop the head entry when pop && !empty
//     full, empty   occupancy flags
//     head_dat      current head entry, straight from storage
// ---------------------------------------------------------------------------
module line_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ofmap_serializer.sv
// ---------------------------------------------------------------------------
// ofmap_serializer
//   Buffers wide ofmap lines (ARRAY_WIDTH words of OFMAP_WIDTH) from the
//   systolic-array drain and emits them word 0 first on a narrow stream.
//   Counts lines per layer and pulses layer_done when the layer has drained.
//
//   Handshakes: a transfer happens on a rising clk edge where vld && rdy.
//   A source holds dat/vld stable until the transfer; rdy outputs of this
//   block depend only on registered state, never on the partner's vld.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     cfg_num_lines/vld/rdy     layer length load (accepted only in IDLE)
//     line_dat/vld/rdy          wide line input
//     ofmap_dat/vld/rdy         word output stream
//     busy                      high while a layer is in progress
//     layer_done                one-cycle pulse after the last word
//     dbg_state                 current FSM state
//
//   Build option: define OFMAP_RELU_EN to clamp negative output words to 0
//   on the output mux (FIFO contents stay raw).
// ---------------------------------------------------------------------------
module ofmap_serializer
  import ofmap_serializer_pkg::*;
#(
  parameter int OFMAP_WIDTH    = DEF_OFMAP_WIDTH,
  parameter int ARRAY_WIDTH    = DEF_ARRAY_WIDTH,
  parameter int FIFO_DEPTH     = 2,
  parameter int LINE_CNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [LINE_CNT_WIDTH-1:0]          cfg_num_lines,
  input  logic                               cfg_vld,
  output logic                               cfg_rdy,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] line_dat,
  input  logic                               line_vld,
  output logic                               line_rdy,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic                               busy,
  output logic                               layer_done,
  output ofmap_ser_state_t                   dbg_state
);

  localparam int LINE_W = OFMAP_WIDTH * ARRAY_WIDTH;
  localparam int SEL_W  = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(ARRAY_WIDTH - 1);

  ofmap_ser_state_t          state_q;
  ofmap_ser_state_t          state_d;
  logic [LINE_CNT_WIDTH-1:0] num_lines_q;
  logic [LINE_CNT_WIDTH-1:0] push_cnt_q;
  logic [LINE_CNT_WIDTH-1:0] pop_cnt_q;
  logic [SEL_W-1:0]          sel_q;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [LINE_W-1:0]         head_dat;
  logic [OFMAP_WIDTH-1:0]    head_word;

  logic cfg_accept;
  logic line_push;
  logic word_hs;
  logic line_pop;
  logic last_line;

  assign cfg_accept = (state_q == IDLE) && cfg_vld && (cfg_num_lines != '0);
  assign line_push  = line_vld && line_rdy;
  assign word_hs    = ofmap_vld && ofmap_rdy;
  assign line_pop   = word_hs && (sel_q == SEL_LAST);
  assign last_line  = (pop_cnt_q == num_lines_q - LINE_CNT_WIDTH'(1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_accept) state_d = RUN;
      RUN:  if (line_pop && last_line) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cfg_rdy    = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign layer_done = (state_q == DONE);
  assign dbg_state  = state_q;

  // Full FIFO blocks pushes even if a pop is happening this cycle: no bypass,
  // and line_rdy stays independent of ofmap_rdy.
  assign line_rdy = (state_q == RUN) && !fifo_full && (push_cnt_q != num_lines_q);

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lines_q <= '0;
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      sel_q       <= '0;
    end else if (cfg_accept) begin
      num_lines_q <= cfg_num_lines;
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      sel_q       <= '0;
    end else begin
      if (line_push) push_cnt_q <= push_cnt_q + LINE_CNT_WIDTH'(1);
      if (word_hs)   sel_q      <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      if (line_pop)  pop_cnt_q  <= pop_cnt_q + LINE_CNT_WIDTH'(1);
    end
  end

  // ---------------- line buffer ----------------
  line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (line_push),
    .push_dat (line_dat),
    .pop      (line_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_dat)
  );

  // ---------------- output word mux ----------------
  always_comb begin
    head_word = '0;
    for (int k = 0; k < ARRAY_WIDTH; k++) begin
      if (sel_q == SEL_W'(k)) head_word = head_dat[k*OFMAP_WIDTH +: OFMAP_WIDTH];
    end
  end

  assign ofmap_vld = !fifo_empty;

  // Forced to 0 while empty so stale storage never shows on the port.
`ifdef OFMAP_RELU_EN
  assign ofmap_dat = (fifo_empty || head_word[OFMAP_WIDTH-1]) ? '0 : head_word;
`else
  assign ofmap_dat = fifo_empty ? '0 : head_word;
`endif

endmodule

// File: tb/tb_ofmap_serializer.sv
module tb_ofmap_serializer;
  import ofmap_serializer_pkg::*;

  localparam int OW = 32;
  localparam int AW = 4;
  localparam int LW = OW * AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]    cfg_num_lines;
  logic           cfg_vld;
  logic           cfg_rdy;
  logic [LW-1:0]  line_dat;
  logic           line_vld;
  logic           line_rdy;
  logic [OW-1:0]  ofmap_dat;
  logic           ofmap_vld;
  logic           ofmap_rdy;
  logic           busy;
  logic           layer_done;
  ofmap_ser_state_t dbg_state;

  ofmap_serializer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_num_lines (cfg_num_lines),
    .cfg_vld       (cfg_vld),
    .cfg_rdy       (cfg_rdy),
    .line_dat      (line_dat),
    .line_vld      (line_vld),
    .line_rdy      (line_rdy),
    .ofmap_dat     (ofmap_dat),
    .ofmap_vld     (ofmap_vld),
    .ofmap_rdy     (ofmap_rdy),
    .busy          (busy),
    .layer_done    (layer_done),
    .dbg_state     (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;  // 0: always 1, 1: 1,0,0,1 pattern, 2: random, 3: always 0
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] relu(input logic [OW-1:0] w);
`ifdef OFMAP_RELU_EN
    return w[OW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < AW; k++) r[k*OW +: OW] = $urandom();
    return r;
  endfunction

  // ---------------- ofmap_rdy driver ----------------
  initial begin
    int ph;
    ph = 0;
    ofmap_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: ofmap_rdy = 1'b1;
        1: ofmap_rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
        2: ofmap_rdy = 1'($urandom_range(0, 1));
        default: ofmap_rdy = 1'b0;
      endcase
      ph++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bit            prev_stall;
    logic [OW-1:0] prev_dat;
    logic [OW-1:0] e;
    prev_stall = 1'b0;
    prev_dat   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_vld", 64'(ofmap_vld), 64'd1);
          chk("hold_dat", 64'(ofmap_dat), 64'(prev_dat));
        end
        if (ofmap_vld && ofmap_rdy) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", ofmap_dat, $time);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'(ofmap_dat), 64'(e));
          end
        end
        if (line_vld && line_rdy)
          for (int k = 0; k < AW; k++) exp_q.push_back(relu(line_dat[k*OW +: OW]));
        if (layer_done) done_cnt++;
        prev_stall = ofmap_vld && !ofmap_rdy;
        prev_dat   = ofmap_dat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_phase(input int mode);
    @(negedge clk);
    rdy_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] n);
    cfg_num_lines = n;
    cfg_vld = 1'b1;
    @(posedge clk);
    #1;
    cfg_vld = 1'b0;
  endtask

  task automatic push_line(input logic [LW-1:0] d);
    line_dat = d;
    line_vld = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (line_rdy) begin
        @(posedge clk);
        #1;
        line_vld = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL push_timeout: got line_rdy=0 expected 1 within 500 cycles");
    line_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (layer_done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got layer_done=0 expected 1 within %0d cycles", budget);
  endtask

  // Single-line layer with cycle-exact checks of latency, order and done.
  task automatic line_direct(input logic [LW-1:0] d, input logic [LW-1:0] e);
    start_phase(0);
    cfg(32'd1);
    push_line(d);
    for (int k = 0; k < AW; k++) begin
      @(negedge clk);
      chk("dir_vld", 64'(ofmap_vld), 64'd1);
      chk("dir_word", 64'(ofmap_dat), 64'(e[k*OW +: OW]));
    end
    @(negedge clk);
    chk("dir_done", 64'(layer_done), 64'd1);
    chk("dir_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("dir_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("dir_done_low", 64'(layer_done), 64'd0);
  endtask

  // ---------------- table-driven layers ----------------
  typedef struct {
    int num_lines;
    int rdy_mode;
    int n_offer;
    int exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    int start_hs;
    int start_done;
    logic [LW-1:0] d;
    logic [LW-1:0] e;

    vecs[0] = '{num_lines: 1, rdy_mode: 0, n_offer: 1, exp_words: 4};
    vecs[1] = '{num_lines: 1, rdy_mode: 1, n_offer: 1, exp_words: 4};
    vecs[2] = '{num_lines: 3, rdy_mode: 2, n_offer: 3, exp_words: 12};
    vecs[3] = '{num_lines: 2, rdy_mode: 0, n_offer: 3, exp_words: 8};
    vecs[4] = '{num_lines: 6, rdy_mode: 1, n_offer: 6, exp_words: 24};

    cfg_num_lines = '0;
    cfg_vld  = 1'b0;
    line_dat = '0;
    line_vld = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vld", 64'(ofmap_vld), 64'd0);
    chk("rst_dat", 64'(ofmap_dat), 64'd0);
    chk("rst_line_rdy", 64'(line_rdy), 64'd0);
    chk("rst_done", 64'(layer_done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-length config is ignored
    start_phase(0);
    cfg(32'd0);
    @(negedge clk);
    chk("zero_cfg_busy", 64'(busy), 64'd0);
    chk("zero_cfg_rdy", 64'(cfg_rdy), 64'd1);

    // Basic order
    d = {32'd4, 32'd3, 32'd2, 32'd1};
    line_direct(d, d);

    // Signed words: clamped with OFMAP_RELU_EN, raw otherwise
    d = {32'hFFFF_FFFB, 32'h0, 32'h7, 32'hFFFF_FFFF};
`ifdef OFMAP_RELU_EN
    e = {32'h0, 32'h0, 32'h7, 32'h0};
`else
    e = d;
`endif
    line_direct(d, e);

    // Table of layers, including backpressure and the line limit
    for (int i = 0; i < 5; i++) begin
      start_phase(vecs[i].rdy_mode);
      start_hs   = hs_cnt;
      start_done = done_cnt;
      cfg(32'(vecs[i].num_lines));
      fork
        begin
          for (int j = 0; j < vecs[i].num_lines; j++) push_line(rand_line());
          if (vecs[i].n_offer > vecs[i].num_lines) begin
            line_dat = rand_line();
            line_vld = 1'b1;
          end
        end
        wait_done(3000);
      join
      @(negedge clk);
      chk("tbl_words", 64'(hs_cnt - start_hs), 64'(vecs[i].exp_words));
      chk("tbl_done_once", 64'(done_cnt - start_done), 64'd1);
      chk("tbl_drained", 64'(exp_q.size()), 64'd0);
      chk("tbl_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("tbl_line_rdy", 64'(line_rdy), 64'd0);
      line_vld = 1'b0;
    end

    // Full FIFO: two lines buffered, third stalled until the first pop
    start_phase(3);
    start_hs = hs_cnt;
    cfg(32'd3);
    push_line(rand_line());
    push_line(rand_line());
    line_dat = rand_line();
    line_vld = 1'b1;
    cfg_num_lines = 32'd1;  // ignored while running
    cfg_vld = 1'b1;
    @(posedge clk);
    #1;
    cfg_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("full_line_rdy", 64'(line_rdy), 64'd0);
    end
    chk("full_busy", 64'(busy), 64'd1);
    rdy_mode = 0;
    push_line(line_dat);
    chk("full_third_after_pop", 64'(hs_cnt - start_hs >= 4), 64'd1);
    wait_done(1000);
    @(negedge clk);
    chk("full_words", 64'(hs_cnt - start_hs), 64'd12);
    chk("full_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-layer after 5 of 8 words
    start_phase(0);
    start_hs = hs_cnt;
    cfg(32'd2);
    push_line(rand_line());
    push_line(rand_line());
    for (int c = 0; c < 200 && (hs_cnt - start_hs) < 5; c++) @(negedge clk);
    chk("mid_words_seen", 64'(hs_cnt - start_hs), 64'd5);
    rdy_mode = 3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_vld", 64'(ofmap_vld), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("mid_rst_done", 64'(layer_done), 64'd0);
    exp_q.delete();
    start_done = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_done", 64'(done_cnt - start_done), 64'd0);

    // Fresh layer after the reset
    start_phase(2);
    start_hs = hs_cnt;
    cfg(32'd2);
    fork
      begin
        push_line(rand_line());
        push_line(rand_line());
      end
      wait_done(1000);
    join
    @(negedge clk);
    chk("post_rst_words", 64'(hs_cnt - start_hs), 64'd8);
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
